// File: rtl/spaceinv_pkg.sv
// Shared constants, state encoding and bus packing helper for the invader logic.
// Pure declarations: no latency, no flow control.
package spaceinv_pkg;

    localparam int H_ACTIVE   = 640;
    localparam int V_ACTIVE   = 480;
    localparam int NUM_INV    = 8;
    localparam int X_MIN_DEF  = 8;
    localparam int X_MAX_DEF  = H_ACTIVE - 16;
    localparam int Y_LAND_DEF = V_ACTIVE - 80;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MARCH,
        ST_LANDED,
        ST_CLEARED
    } inv_state_t;

    // LSB of slot idx inside a packed 10-bit-per-slot bus
    function automatic int slot_lsb(input int idx);
        return 10 * idx;
    endfunction

endpackage

// File: rtl/formation_extent.sv
// Combinational extent of the live formation: leftmost X, rightmost right edge, dead count.
// Zero latency; no flow control. Outputs are don't-care when no slot is alive.
module formation_extent #(
    parameter int NUM_INV   = 8,
    parameter int X_SPACING = 50,
    parameter int INV_W     = 32
) (
    input  logic [NUM_INV-1:0] i_alive,
    input  logic [9:0]         i_base_x,
    output logic [10:0]        o_leftmost_x,
    output logic [10:0]        o_rightmost_edge,
    output logic [3:0]         o_dead_count
);
    import spaceinv_pkg::*;

    int   w_lo;
    int   w_hi;
    int   w_dead;
    logic w_found;

    always_comb begin
        w_lo    = 0;
        w_hi    = 0;
        w_dead  = 0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_INV; i++) begin
            if (i_alive[i]) begin
                if (!w_found) w_lo = i;
                w_found = 1'b1;
                w_hi    = i;
            end else begin
                w_dead = w_dead + 1;
            end
        end
    end

    assign o_leftmost_x     = 11'(int'(i_base_x) + w_lo * X_SPACING);
    assign o_rightmost_edge = 11'(int'(i_base_x) + w_hi * X_SPACING + INV_W);
    assign o_dead_count     = 4'(w_dead);

endmodule

// File: rtl/invader_formation_ctrl.sv
// Invader formation controller: marches/drops the 8-slot block every N frames and applies kills.
// State updates one edge after frame_tick/hit/start; positions follow the base registers; no backpressure.
module invader_formation_ctrl #(
    parameter int NUM_INV         = spaceinv_pkg::NUM_INV,
    parameter int X_START         = 200,
    parameter int X_SPACING       = 50,
    parameter int Y_START         = 50,
    parameter int INV_W           = 32,
    parameter int STEP_X          = 4,
    parameter int STEP_Y          = 16,
    parameter int X_MIN           = spaceinv_pkg::X_MIN_DEF,
    parameter int X_MAX           = spaceinv_pkg::X_MAX_DEF,
    parameter int Y_LAND          = spaceinv_pkg::Y_LAND_DEF,
    parameter int FRAMES_PER_STEP = 30,
    parameter int SPEEDUP         = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_frame_tick,
    input  logic                    i_start,
    input  logic                    i_hit_valid,
    input  logic [2:0]              i_hit_idx,
    output logic [10*NUM_INV-1:0]   o_pos_x,
    output logic [10*NUM_INV-1:0]   o_pos_y,
    output logic [NUM_INV-1:0]      o_alive,
    output logic                    o_step_pulse,
    output logic                    o_landed,
    output logic                    o_cleared
);
    import spaceinv_pkg::*;

    inv_state_t         r_state;
    logic               r_dir_left;
    logic [7:0]         r_frame_cnt;
    logic [9:0]         r_base_x;
    logic [9:0]         r_base_y;
    logic [NUM_INV-1:0] r_alive;
    logic               r_step_pulse;
    logic               r_landed;
    logic               r_cleared;

    logic [10:0]        w_leftmost_x;
    logic [10:0]        w_rightmost_edge;
    logic [3:0]         w_dead_count;
    int                 w_penalty;
    logic [7:0]         w_period;
    logic               w_step_due;
    logic               w_hit_kill;
    logic [NUM_INV-1:0] w_alive_hit;
    logic               w_at_edge;
    logic [9:0]         w_drop_y;
    logic               w_lands;

    formation_extent #(
        .NUM_INV   (NUM_INV),
        .X_SPACING (X_SPACING),
        .INV_W     (INV_W)
    ) u_extent (
        .i_alive          (r_alive),
        .i_base_x         (r_base_x),
        .o_leftmost_x     (w_leftmost_x),
        .o_rightmost_edge (w_rightmost_edge),
        .o_dead_count     (w_dead_count)
    );

    // Period and edge test both see the pre-hit mask, so a same-edge kill affects only the next step
    assign w_penalty  = SPEEDUP * int'(w_dead_count);
    assign w_period   = (FRAMES_PER_STEP - w_penalty < 2) ? 8'd2 : 8'(FRAMES_PER_STEP - w_penalty);
    // >= rather than == so a period shrinking below a running count cannot stall the march
    assign w_step_due = i_frame_tick && (r_frame_cnt >= w_period - 8'd1);
    assign w_hit_kill = i_hit_valid && r_alive[i_hit_idx];
    assign w_at_edge  = r_dir_left ? (w_leftmost_x < 11'(X_MIN + STEP_X))
                                   : (w_rightmost_edge + 11'(STEP_X) > 11'(X_MAX));
    assign w_drop_y   = r_base_y + 10'(STEP_Y);
    assign w_lands    = ({1'b0, w_drop_y} + 11'(INV_W)) >= 11'(Y_LAND);

    always_comb begin
        w_alive_hit = r_alive;
        if (w_hit_kill) w_alive_hit[i_hit_idx] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_dir_left   <= 1'b0;
            r_frame_cnt  <= '0;
            r_base_x     <= 10'(X_START);
            r_base_y     <= 10'(Y_START);
            r_alive      <= '1;
            r_step_pulse <= 1'b0;
            r_landed     <= 1'b0;
            r_cleared    <= 1'b0;
        end else begin
            r_step_pulse <= 1'b0;
            if (i_start) begin
                r_state     <= ST_MARCH;
                r_dir_left  <= 1'b0;
                r_frame_cnt <= '0;
                r_base_x    <= 10'(X_START);
                r_base_y    <= 10'(Y_START);
                r_alive     <= '1;
                r_landed    <= 1'b0;
                r_cleared   <= 1'b0;
            end else if (r_state == ST_MARCH) begin
                if (r_alive == '0) begin
                    r_state   <= ST_CLEARED;
                    r_cleared <= 1'b1;
                end else begin
                    r_alive <= w_alive_hit;
                    if (w_step_due) begin
                        r_frame_cnt  <= '0;
                        r_step_pulse <= 1'b1;
                        if (w_at_edge) begin
                            r_base_y   <= w_drop_y;
                            r_dir_left <= ~r_dir_left;
                            // a last kill on this edge defers to CLEARED next cycle
                            if (w_lands && (w_alive_hit != '0)) begin
                                r_state  <= ST_LANDED;
                                r_landed <= 1'b1;
                            end
                        end else if (r_dir_left) begin
                            r_base_x <= r_base_x - 10'(STEP_X);
                        end else begin
                            r_base_x <= r_base_x + 10'(STEP_X);
                        end
                    end else if (i_frame_tick) begin
                        r_frame_cnt <= r_frame_cnt + 8'd1;
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_INV; i++) begin : g_slot
        assign o_pos_x[slot_lsb(i) +: 10] = r_base_x + 10'(i * X_SPACING);
        assign o_pos_y[slot_lsb(i) +: 10] = r_base_y;
    end

    assign o_alive      = r_alive;
    assign o_step_pulse = r_step_pulse;
    assign o_landed     = r_landed;
    assign o_cleared    = r_cleared;

endmodule
